// File: rtl/mul_ctrl_pkg.sv
// Shared widths and pipeline-stage records for the multiplier arbiter slice.
package mul_ctrl_pkg;

    localparam int unsigned MUL_W     = 32;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned N_REQ_MAX = 4;
    localparam int unsigned ID_MAX_W  = $clog2(N_REQ_MAX);

    typedef struct packed {
        logic [MUL_W-1:0]    a;
        logic [MUL_W-1:0]    b;
        logic [ID_MAX_W-1:0] id;
        logic                v;
    } s1_t;

    typedef struct packed {
        logic [PROD_W-1:0]   prod;
        logic [ID_MAX_W-1:0] id;
        logic                v;
    } s2_t;

endpackage

// File: rtl/mul_32_32.sv
// Combinational 32x32 -> 64 multiplier; behavioural stand-in for the Booth/Wallace datapath.
module mul_32_32 (
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic [63:0] mul_pro
);

    assign mul_pro = 64'(mul_a) * 64'(mul_b);

endmodule

// File: rtl/rr_arb.sv
// Rotating-priority arbiter: search starts at ptr, ptr moves past the winner on a grant.
module rr_arb
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  win_id,
    output logic [ID_W-1:0]  ptr
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign grant = (found && advance) ? (N_REQ'(1) << win_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found && advance) begin
            ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/mul_32_32_arb.sv
// Shares one mul_32_32 between N_REQ requesters through a two-stage pipeline.
// Optional perf counters: define MUL_ARB_PERF_EN.
module mul_32_32_arb
    import mul_ctrl_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [63:0]         resp_data,
    output logic [ID_W-1:0]     resp_id
`ifdef MUL_ARB_PERF_EN
    ,output logic [N_REQ*32-1:0] perf_grant_cnt
    ,output logic [31:0]         perf_stall_cnt
`endif
);

    s1_t              s1;
    s2_t              s2;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  ptr;
    logic [MUL_W-1:0] sel_a;
    logic [MUL_W-1:0] sel_b;
    logic [PROD_W-1:0] prod;
    logic             unused_bits;

    assign s2_adv = !s2.v || resp_ready;
    assign s1_adv = !s1.v || s2_adv;

    rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (s1_adv && !rst),
        .grant   (grant),
        .win_id  (win_id),
        .ptr     (ptr)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_a     = req_a[32'(win_id)*MUL_W +: MUL_W];
    assign sel_b     = req_b[32'(win_id)*MUL_W +: MUL_W];

    mul_32_32 u_mul (
        .mul_a   (s1.a),
        .mul_b   (s1.b),
        .mul_pro (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            if (s2_adv) begin
                s2 <= '{prod: prod, id: s1.id, v: s1.v};
            end
            // an accept implies S1 is empty or draining into S2 this same edge
            if (accept) begin
                s1 <= '{a: sel_a, b: sel_b, id: ID_MAX_W'(win_id), v: 1'b1};
            end else if (s2_adv) begin
                s1.v <= 1'b0;
            end
        end
    end

    assign resp_valid  = s2.v;
    assign resp_data   = s2.prod;
    assign resp_id     = s2.id[ID_W-1:0];
    assign unused_bits = ^{ptr, s2.id};

`ifdef MUL_ARB_PERF_EN
    logic [31:0] grant_cnt [N_REQ];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
            if (s2.v && !resp_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) perf_grant_cnt[i*32 +: 32] = grant_cnt[i];
    end
    assign perf_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_mul_32_32_arb.sv
// Self-checking bench for mul_32_32_arb: directed scenarios plus randomized traffic vs a scoreboard.
module tb_mul_32_32_arb;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [63:0]     resp_data;
    logic [IW-1:0]   resp_id;
`ifdef MUL_ARB_PERF_EN
    logic [N*32-1:0] perf_grant_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    mul_32_32_arb #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef MUL_ARB_PERF_EN
        ,.perf_grant_cnt (perf_grant_cnt)
        ,.perf_stall_cnt (perf_stall_cnt)
`endif
    );

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    logic [N-1:0] vld;

    assign req_valid = vld;
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
    end

    typedef struct {
        logic [63:0] prod;
        int          id;
        int          acc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           mptr = 0;
    int           n_acc = 0;
    int           n_resp = 0;
    int           gcnt [N];
    int           scnt = 0;
    int           w;
    int           j;
    logic [N-1:0] exp_ready;
    logic [N-1:0] fired = '0;
    logic [63:0]  hold_data;
    logic [IW-1:0] hold_id;
    int           n_checks = 0;
    int           n_pass = 0;
    int           r0;
    int           a0;
    int           nxt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: rotating priority from the last winner, a FIFO of accepted
    // operand pairs, and the rule that the oldest item is presented two cycles after acceptance.
    always @(negedge clk) begin
        cyc++;
        fired = '0;
        if (rst) begin
            sb.delete();
            mptr = 0;
            scnt = 0;
            for (int i = 0; i < N; i++) gcnt[i] = 0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (w < 0 && vld[j]) w = j;
            end
            exp_ready = '0;
            if (w >= 0 && (sb.size() < 2 || resp_ready)) exp_ready[w] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("resp_valid", 64'(resp_valid), 64'(sb.size() > 0 && (cyc - sb[0].acc) >= 2));
            if (resp_valid && sb.size() > 0) begin
                check("resp_data", resp_data, sb[0].prod);
                check("resp_id", 64'(resp_id), 64'(sb[0].id));
                if (resp_ready) begin
                    void'(sb.pop_front());
                    n_resp++;
                end
            end
            if (resp_valid && !resp_ready) scnt++;
            fired = vld & req_ready;
            for (int i = 0; i < N; i++) begin
                if (fired[i]) begin
                    sb.push_back('{prod: 64'(op_a[i]) * 64'(op_b[i]), id: i, acc: cyc});
                    gcnt[i]++;
                    n_acc++;
                    mptr = (i + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fired[i]) vld[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        vld = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        vld = '1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_data", resp_data, 64'(0));
        check("rst_resp_id", 64'(resp_id), 64'(0));
        step();
        vld = '0;
        rst = 1'b0;
        step();

        // accept and latency
        resp_ready = 1'b1;
        op_a[0] = 32'd3;
        op_b[0] = 32'd5;
        vld[0] = 1'b1;
        step();
        @(negedge clk);
        check("lat_s1_only", 64'(resp_valid), 64'(0));
        step();
        @(negedge clk);
        check("lat_valid", 64'(resp_valid), 64'(1));
        check("lat_data", resp_data, 64'd15);
        check("lat_id", 64'(resp_id), 64'(0));
        step();
        @(negedge clk);
        check("lat_one_cycle", 64'(resp_valid), 64'(0));

        // wide operands from requester 1
        op_a[1] = 32'h0001_0000;
        op_b[1] = 32'h0001_0000;
        vld[1] = 1'b1;
        step();
        step();
        @(negedge clk);
        check("wide_valid", 64'(resp_valid), 64'(1));
        check("wide_data", resp_data, 64'h0000_0001_0000_0000);
        check("wide_id", 64'(resp_id), 64'(1));
        step();

        // fairness and full throughput: 8 back-to-back accepts
        r0 = n_resp;
        a0 = n_acc;
        op_a[0] = 32'd0; op_b[0] = 32'd2;
        op_a[1] = 32'd1; op_b[1] = 32'd2;
        vld = '1;
        nxt = 2;
        repeat (8) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && nxt < 8) begin
                    op_a[i] = 32'(nxt);
                    op_b[i] = 32'd2;
                    vld[i] = 1'b1;
                    nxt++;
                end
            end
        end
        check("fair_accepts", 64'(n_acc - a0), 64'd8);
        check("fair_resp_inflight", 64'(n_resp - r0), 64'd6);
        step();
        step();
        check("fair_resp_total", 64'(n_resp - r0), 64'd8);

        // backpressure: fill both stages, stall 4 cycles with a third request pending
        resp_ready = 1'b0;
        op_a[0] = 32'h1234_5678; op_b[0] = 32'h0000_0abc;
        op_a[1] = 32'h7fff_ffff; op_b[1] = 32'h7fff_fffe;
        vld = '1;
        step();
        step();
        op_a[0] = 32'h0bad_cafe;
        op_b[0] = 32'h0000_1001;
        vld[0] = 1'b1;
        @(negedge clk);
        hold_data = resp_data;
        hold_id = resp_id;
        repeat (4) step();
        @(negedge clk);
        check("bp_data_stable", resp_data, hold_data);
        check("bp_id_stable", 64'(resp_id), 64'(hold_id));
        check("bp_no_ready", 64'(req_ready), 64'(0));
        resp_ready = 1'b1;
        repeat (6) step();
        check("bp_drained", 64'(sb.size()), 64'(0));
        check("bp_third_taken", 64'(vld), 64'(0));

        // reset mid-flight with a non-zero pointer
        resp_ready = 1'b0;
        op_a[0] = 32'd11; op_b[0] = 32'd13;
        op_a[1] = 32'd17; op_b[1] = 32'd19;
        vld = '1;
        step();
        step();
        vld = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_resp_valid", 64'(resp_valid), 64'(0));
        step();
        vld = '1;
        @(negedge clk);
        check("rst_mid_ptr0", 64'(req_ready), 64'b01);
        resp_ready = 1'b1;
        repeat (6) step();

        // randomized traffic with random backpressure
        repeat (400) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    op_a[i] = $urandom & 32'h7fff_ffff;
                    op_b[i] = $urandom & 32'h7fff_ffff;
                    vld[i] = 1'b1;
                end
            end
            step();
        end
        resp_ready = 1'b1;
        repeat (12) step();
        check("rand_drained", 64'(sb.size()), 64'(0));
        check("rand_req_idle", 64'(vld), 64'(0));

`ifdef MUL_ARB_PERF_EN
        for (int i = 0; i < N; i++) check("perf_grant", 64'(perf_grant_cnt[i*32 +: 32]), 64'(gcnt[i]));
        check("perf_stall", 64'(perf_stall_cnt), 64'(scnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
